// File: rtl/sensor_arb_pkg.sv
// Shared types and defaults for the sensor channel arbiter.
package sensor_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

    localparam int unsigned DEF_START_HOLD     = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/sensor_arbiter_rr.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = |req_i;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant_i) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sensor_arbiter.sv
// Shares one I2C sensor channel among N_REQ requesters: round-robin grant,
// start pulse, completion/timeout detection and one-hot response.
module sensor_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned START_HOLD     = DEF_START_HOLD,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_mode,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_timeout,
    output logic               busy,
    output logic               sns_start,
    output logic               sns_mode,
    output logic [6:0]         sns_addr,
    output logic [7:0]         sns_wdata,
    input  logic               sns_data_ready,
    input  logic [7:0]         sns_read_val
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HW = $clog2(START_HOLD + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            done_q, done_d;
    logic            dr_q;
    logic            mode_q, mode_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            timeout_q, timeout_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic             dr_rise;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (grant_q),
        .grant_o      (arb_gnt),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    assign dr_rise = sns_data_ready & ~dr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= IW'(N_REQ - 1);
            hold_q    <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            dr_q      <= 1'b0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            dr_q      <= sns_data_ready;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        done_d    = done_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = ISSUE;
                    grant_d = arb_idx;
                    hold_d  = '0;
                    done_d  = 1'b0;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            mode_d  = req_mode[i];
                            addr_d  = req_addr[7*i +: 7];
                            wdata_d = req_wdata[8*i +: 8];
                        end
                    end
                end
            end
            ISSUE: begin
                // A fast channel may finish while start is still held; remember it.
                if (dr_rise) done_d = 1'b1;
                if (hold_q == HW'(START_HOLD - 1)) begin
                    state_d = WAIT;
                    tmo_d   = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            WAIT: begin
                if (dr_rise || done_q) begin
                    state_d   = RESP;
                    rdata_d   = (mode_q == MODE_READ) ? sns_read_val : 8'h00;
                    timeout_d = 1'b0;
                    done_d    = 1'b0;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    rdata_d   = 8'h00;
                    timeout_d = 1'b1;
                end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                req_ready[i] = (state_q == ISSUE) && (hold_q == '0);
                rsp_valid[i] = (state_q == RESP);
            end
        end
        busy        = (state_q != IDLE);
        sns_start   = (state_q == ISSUE);
        sns_mode    = mode_q;
        sns_addr    = addr_q;
        sns_wdata   = wdata_q;
        rsp_rdata   = rdata_q;
        rsp_timeout = timeout_q;
    end

endmodule

// File: tb/tb_sensor_arbiter.sv
// Randomized and directed bench for sensor_arbiter against a transaction-level model.
module tb_sensor_arbiter;

    localparam int N = 4;
    localparam int S = 8;
    localparam int T = 4096;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_mode;
    logic [7*N-1:0]   req_addr;
    logic [8*N-1:0]   req_wdata;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [7:0]       rsp_rdata;
    logic             rsp_timeout;
    logic             busy;
    logic             sns_start;
    logic             sns_mode;
    logic [6:0]       sns_addr;
    logic [7:0]       sns_wdata;
    logic             sns_data_ready;
    logic [7:0]       sns_read_val;

    sensor_arbiter #(
        .N_REQ          (N),
        .START_HOLD     (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_mode       (req_mode),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .sns_start      (sns_start),
        .sns_mode       (sns_mode),
        .sns_addr       (sns_addr),
        .sns_wdata      (sns_wdata),
        .sns_data_ready (sns_data_ready),
        .sns_read_val   (sns_read_val)
    );

    always #5 clock = ~clock;

    // Number of the most recent rising clock edge.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [N-1:0] pend;
    logic       mode_a [N];
    logic [6:0] addr_a [N];
    logic [7:0] wdata_a [N];
    int         last_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int off = 1; off <= N; off++) begin
            if (p[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_mode[i]          = mode_a[i];
            req_addr[7*i +: 7]   = addr_a[i];
            req_wdata[8*i +: 8]  = wdata_a[i];
        end
    endtask

    task automatic check_idle_outs(input string p);
        check_eq({p, "_ready"},   32'(req_ready),   0);
        check_eq({p, "_rspv"},    32'(rsp_valid),   0);
        check_eq({p, "_tmo"},     32'(rsp_timeout), 0);
        check_eq({p, "_busy"},    32'(busy),        0);
        check_eq({p, "_start"},   32'(sns_start),   0);
        check_eq({p, "_rdata"},   32'(rsp_rdata),   0);
        check_eq({p, "_smode"},   32'(sns_mode),    0);
        check_eq({p, "_saddr"},   32'(sns_addr),    0);
        check_eq({p, "_swdata"},  32'(sns_wdata),   0);
    endtask

    // Called at a falling edge with the DUT idle. k<0: channel never completes;
    // otherwise data_ready rises k cycles after the grant is visible.
    // keep: 0 requester drops after grant, 1 keeps requesting, 2 random.
    task automatic txn(input int k, input logic [7:0] rv, input int keep);
        int s, g, ce, cnt, extra;
        bit seen;
        logic gmode;
        logic [6:0] gaddr;
        logic [7:0] gwdata;
        drive_reqs();
        s = cyc + 1;
        g = rr_pick(pend, last_g);
        if (g < 0) begin
            check_eq("model_nopend", 0, 1);
            return;
        end
        last_g = g;
        gmode = mode_a[g];
        gaddr = addr_a[g];
        gwdata = wdata_a[g];
        @(negedge clock);
        check_eq("ready", 32'(req_ready), 32'(1) << g);
        check_eq("busy_issue", 32'(busy), 1);
        check_eq("sns_mode", 32'(sns_mode), 32'(gmode));
        check_eq("sns_addr", 32'(sns_addr), 32'(gaddr));
        check_eq("sns_wdata", 32'(sns_wdata), 32'(gwdata));
        if (keep == 0 || (keep == 2 && $urandom_range(0, 3) != 0)) pend[g] = 1'b0;
        drive_reqs();
        cnt = sns_start ? 1 : 0;
        extra = 0;
        seen = 0;
        if (k < 0) ce = s + S + T;
        else ce = (s + k + 1 > s + S + 1) ? s + k + 1 : s + S + 1;
        if (k == 0) begin
            sns_data_ready = 1'b1;
            sns_read_val = rv;
        end
        repeat (S + T + 200) begin
            @(negedge clock);
            if (rsp_valid != '0) begin
                seen = 1;
                break;
            end
            if (sns_start) cnt++;
            if (req_ready != '0) extra++;
            if (k > 0 && cyc == s + k) begin
                sns_data_ready = 1'b1;
                sns_read_val = rv;
            end
        end
        check_eq("rsp_seen", 32'(seen), 1);
        check_eq("rsp_cycle", cyc, ce);
        check_eq("rsp_onehot", 32'(rsp_valid), 32'(1) << g);
        check_eq("rsp_rdata", 32'(rsp_rdata), (k >= 0 && gmode) ? 32'(rv) : 0);
        check_eq("rsp_timeout", 32'(rsp_timeout), (k < 0) ? 1 : 0);
        check_eq("start_len", cnt, S);
        check_eq("ready_extra", extra, 0);
        check_eq("addr_held", 32'(sns_addr), 32'(gaddr));
        sns_data_ready = 1'b0;
        @(negedge clock);
        check_eq("busy_after", 32'(busy), 0);
        check_eq("rsp_once", 32'(rsp_valid), 0);
    endtask

    initial begin
        int s;
        logic [N-1:0] add;
        reset = 1'b1;
        pend = '0;
        for (int i = 0; i < N; i++) begin
            mode_a[i] = 1'b0;
            addr_a[i] = '0;
            wdata_a[i] = '0;
        end
        drive_reqs();
        sns_data_ready = 1'b0;
        sns_read_val = '0;
        last_g = N - 1;
        repeat (3) @(negedge clock);
        check_idle_outs("rst");
        reset = 1'b0;
        @(negedge clock);

        // Single read from requester 0.
        pend = 4'b0001;
        mode_a[0] = 1'b1; addr_a[0] = 7'h48; wdata_a[0] = 8'h00;
        txn(40, 8'hA5, 0);

        // Write from requester 2.
        pend = 4'b0100;
        mode_a[2] = 1'b0; addr_a[2] = 7'h1D; wdata_a[2] = 8'h3C;
        txn(5, 8'h77, 0);

        // Timeout on requester 1.
        pend = 4'b0010;
        mode_a[1] = 1'b1; addr_a[1] = 7'h55; wdata_a[1] = 8'h9E;
        txn(-1, 8'h00, 0);

        // Reset during WAIT.
        pend = 4'b0010;
        drive_reqs();
        s = cyc + 1;
        @(negedge clock);
        pend = '0;
        drive_reqs();
        while (cyc < s + S + 5) @(negedge clock);
        check_eq("midwait_busy", 32'(busy), 1);
        check_eq("midwait_start", 32'(sns_start), 0);
        sns_data_ready = 1'b1;
        sns_read_val = 8'hC3;
        reset = 1'b1;
        @(negedge clock);
        check_idle_outs("rst_wait");
        sns_data_ready = 1'b0;
        @(negedge clock);
        check_eq("rst_wait_rspv2", 32'(rsp_valid), 0);
        reset = 1'b0;
        last_g = N - 1;
        @(negedge clock);
        check_eq("post_rst_rspv", 32'(rsp_valid), 0);

        // All requesters held: expect 0,1,2,3,0.
        pend = 4'b1111;
        for (int i = 0; i < N; i++) begin
            mode_a[i] = i[0];
            addr_a[i] = 7'(7'h10 + i);
            wdata_a[i] = 8'(8'hA0 + i);
        end
        for (int i = 0; i < 5; i++) txn(3 + i, 8'(8'h50 + i), 1);
        pend = '0;
        drive_reqs();
        @(negedge clock);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            add = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (add[i] && !pend[i]) begin
                    pend[i] = 1'b1;
                    mode_a[i] = 1'($urandom);
                    addr_a[i] = 7'($urandom);
                    wdata_a[i] = 8'($urandom);
                end
            end
            txn($urandom_range(0, 30), 8'($urandom), 2);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad + 1);
        $fatal(1);
    end

endmodule
